segment_transition_ctl: RTL and testbench

Sequencer that owns the active read segment (0/1) of one double-buffered datapath, either modulation or STM; one instance serves each. It latches a segment-change request and its transition mode/value from the controller register file. It commits the switch when the mode's condition holds, and counts loop repetitions of the active segment to assert stop or auto-swap. It sits between the controller BRAM register decoder and the segment index counter.

---
 rtl/segment_transition_ctl.sv | 237 +++++++++++++++++++++++
 tb/tb_segment_transition_ctl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/segment_transition_ctl.sv
// -----------------------------------------------------------------------------
// segment_transition_ctl
//
// Owns the active read segment (0/1) of one double-buffered datapath
// (modulation or STM). A segment-change request (segment, mode, value) is
// latched on UPDATE. It is committed once the condition selected by the mode
// holds:
//   SYNC_IDX (0x00) : next LOOP_END
//   SYS_TIME (0x01) : SYS_TIME >= VALUE[SysTimeWidth-1:0]
//   GPIO     (0x02) : rising edge of GPIO_IN[VALUE[1:0]]
//   EXT      (0xF0) : immediately, then auto-swap whenever repetitions end
// The loop repetitions of the active segment are counted. When the count is
// exhausted the block either raises STOP or, in EXT mode, swaps segments.
//
// Ports
//   CLK, RST_N          clock, asynchronous active-low reset
//   UPDATE              one-cycle pulse, latch REQ_SEGMENT/MODE/VALUE
//   REQ_SEGMENT         requested read segment
//   MODE, VALUE         transition mode and its parameter
//   REP0, REP1          repetitions of segment 0/1 (loops = REP+1, all-ones = infinite)
//   SYS_TIME            free-running synchronized system time
//   GPIO_IN             synchronized external trigger inputs
//   LOOP_END            last index of the active segment consumed
//   SEGMENT             active read segment
//   START               one-cycle pulse on every commit (index counter restarts)
//   STOP                repetitions of the active segment exhausted
//   PENDING             a request is latched but not yet committed
//   ERR                 sticky unsupported-mode flag, cleared by next valid UPDATE
// -----------------------------------------------------------------------------
module segment_transition_ctl #(
    parameter int SysTimeWidth = 56,
    parameter int RepWidth     = 16
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    UPDATE,
    input  logic                    REQ_SEGMENT,
    input  logic [7:0]              MODE,
    input  logic [63:0]             VALUE,
    input  logic [RepWidth-1:0]     REP0,
    input  logic [RepWidth-1:0]     REP1,
    input  logic [SysTimeWidth-1:0] SYS_TIME,
    input  logic [3:0]              GPIO_IN,
    input  logic                    LOOP_END,
    output logic                    SEGMENT,
    output logic                    START,
    output logic                    STOP,
    output logic                    PENDING,
    output logic                    ERR
);

    localparam logic [7:0] MODE_SYNC_IDX = 8'h00;
    localparam logic [7:0] MODE_SYS_TIME = 8'h01;
    localparam logic [7:0] MODE_GPIO     = 8'h02;
    localparam logic [7:0] MODE_EXT      = 8'hF0;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_WAIT_LOOP = 2'd1,
        ST_WAIT_TIME = 2'd2,
        ST_WAIT_GPIO = 2'd3
    } state_t;

    state_t                  state_q,    state_d;
    logic                    segment_q,  segment_d;
    logic                    start_q,    start_d;
    logic                    stop_q,     stop_d;
    logic                    pending_q,  pending_d;
    logic                    err_q,      err_d;
    logic                    ext_mode_q, ext_mode_d;
    logic                    req_seg_q,  req_seg_d;
    logic [SysTimeWidth-1:0] req_val_q,  req_val_d;
    logic [RepWidth-1:0]     loop_cnt_q, loop_cnt_d;
    logic [3:0]              gpio_prev_q;

    logic [RepWidth-1:0]     rep_sel_s;
    logic                    rep_inf_s;
    logic                    mode_valid_s;
    logic                    cond_met_s;
    logic                    eor_s;
    logic [1:0]              gpio_sel_s;

    // Only the low SysTimeWidth bits of VALUE are stored; the rest is folded
    // into a sink so every input bit is consumed.
    logic                    unused_value_s;
    assign unused_value_s = ^VALUE;

    assign rep_sel_s  = segment_q ? REP1 : REP0;
    assign rep_inf_s  = &rep_sel_s;
    assign gpio_sel_s = req_val_q[1:0];

    // Supported transition modes.
    always_comb begin
        case (MODE)
            MODE_SYNC_IDX: mode_valid_s = 1'b1;
            MODE_SYS_TIME: mode_valid_s = 1'b1;
            MODE_GPIO:     mode_valid_s = 1'b1;
            MODE_EXT:      mode_valid_s = 1'b1;
            default:       mode_valid_s = 1'b0;
        endcase
    end

    // Commit condition of the pending request for the current wait state.
    always_comb begin
        case (state_q)
            ST_WAIT_LOOP: cond_met_s = LOOP_END;
            ST_WAIT_TIME: cond_met_s = (SYS_TIME >= req_val_q);
            ST_WAIT_GPIO: cond_met_s = GPIO_IN[gpio_sel_s] & ~gpio_prev_q[gpio_sel_s];
            ST_RUN:       cond_met_s = 1'b0;
            default:      cond_met_s = 1'b0;
        endcase
    end

    // Next-state logic: UPDATE has priority over a commit condition, and a
    // commit has priority over repetition counting.
    always_comb begin
        state_d    = state_q;
        segment_d  = segment_q;
        start_d    = 1'b0;
        stop_d     = stop_q;
        pending_d  = pending_q;
        err_d      = err_q;
        ext_mode_d = ext_mode_q;
        req_seg_d  = req_seg_q;
        req_val_d  = req_val_q;
        loop_cnt_d = loop_cnt_q;
        eor_s      = 1'b0;

        // Repetition counting; overridden below whenever a commit happens.
        // Once STOP is raised further loop ends are ignored.
        if (LOOP_END && !stop_q && !rep_inf_s) begin
            if (loop_cnt_q == rep_sel_s) begin
                eor_s = 1'b1;
            end else if (loop_cnt_q != {RepWidth{1'b1}}) begin
                loop_cnt_d = loop_cnt_q + {{(RepWidth-1){1'b0}}, 1'b1};
            end else begin
                loop_cnt_d = loop_cnt_q;
            end
        end else begin
            eor_s = 1'b0;
        end

        if (UPDATE) begin
            // Any new request drops the pending one and leaves EXT behaviour.
            ext_mode_d = 1'b0;
            pending_d  = 1'b0;
            state_d    = ST_RUN;
            if (eor_s) begin
                stop_d = 1'b1;
            end else begin
                stop_d = stop_q;
            end
            if (!mode_valid_s) begin
                err_d = 1'b1;
            end else begin
                err_d     = 1'b0;
                req_seg_d = REQ_SEGMENT;
                req_val_d = VALUE[SysTimeWidth-1:0];
                if ((REQ_SEGMENT == segment_q) || (MODE == MODE_EXT)) begin
                    // Same segment or EXT: restart right away.
                    segment_d  = REQ_SEGMENT;
                    start_d    = 1'b1;
                    loop_cnt_d = {RepWidth{1'b0}};
                    stop_d     = 1'b0;
                    ext_mode_d = (MODE == MODE_EXT);
                end else begin
                    pending_d = 1'b1;
                    case (MODE)
                        MODE_SYNC_IDX: state_d = ST_WAIT_LOOP;
                        MODE_SYS_TIME: state_d = ST_WAIT_TIME;
                        MODE_GPIO:     state_d = ST_WAIT_GPIO;
                        default: begin
                            state_d   = ST_RUN;
                            pending_d = 1'b0;
                        end
                    endcase
                end
            end
        end else if (cond_met_s) begin
            segment_d  = req_seg_q;
            start_d    = 1'b1;
            loop_cnt_d = {RepWidth{1'b0}};
            stop_d     = 1'b0;
            pending_d  = 1'b0;
            state_d    = ST_RUN;
        end else if (eor_s) begin
            if (ext_mode_q) begin
                // Auto-swap; ext_mode stays set so the ping-pong continues.
                segment_d  = ~segment_q;
                start_d    = 1'b1;
                loop_cnt_d = {RepWidth{1'b0}};
                stop_d     = 1'b0;
            end else begin
                stop_d = 1'b1;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_RUN;
            segment_q   <= 1'b0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            pending_q   <= 1'b0;
            err_q       <= 1'b0;
            ext_mode_q  <= 1'b0;
            req_seg_q   <= 1'b0;
            req_val_q   <= {SysTimeWidth{1'b0}};
            loop_cnt_q  <= {RepWidth{1'b0}};
            gpio_prev_q <= 4'b0000;
        end else begin
            state_q     <= state_d;
            segment_q   <= segment_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            pending_q   <= pending_d;
            err_q       <= err_d;
            ext_mode_q  <= ext_mode_d;
            req_seg_q   <= req_seg_d;
            req_val_q   <= req_val_d;
            loop_cnt_q  <= loop_cnt_d;
            // Edge reference is sampled in every state.
            gpio_prev_q <= GPIO_IN;
        end
    end

    assign SEGMENT = segment_q;
    assign START   = start_q;
    assign STOP    = stop_q;
    assign PENDING = pending_q;
    assign ERR     = err_q;

endmodule

// File: tb/tb_segment_transition_ctl.sv
// -----------------------------------------------------------------------------
// Directed testbench for segment_transition_ctl: sync-index, system-time,
// GPIO and EXT transitions, repetition counting, error handling, overlapping
// UPDATE and asynchronous reset. Inputs change 1 ns after the rising edge and
// outputs are checked at the same point.
// -----------------------------------------------------------------------------
module tb_segment_transition_ctl;

    logic        CLK;
    logic        RST_N;
    logic        UPDATE;
    logic        REQ_SEGMENT;
    logic [7:0]  MODE;
    logic [63:0] VALUE;
    logic [15:0] REP0;
    logic [15:0] REP1;
    logic [55:0] SYS_TIME;
    logic [3:0]  GPIO_IN;
    logic        LOOP_END;
    logic        SEGMENT;
    logic        START;
    logic        STOP;
    logic        PENDING;
    logic        ERR;

    int checks;
    int failures;

    segment_transition_ctl #(
        .SysTimeWidth(56),
        .RepWidth    (16)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .UPDATE     (UPDATE),
        .REQ_SEGMENT(REQ_SEGMENT),
        .MODE       (MODE),
        .VALUE      (VALUE),
        .REP0       (REP0),
        .REP1       (REP1),
        .SYS_TIME   (SYS_TIME),
        .GPIO_IN    (GPIO_IN),
        .LOOP_END   (LOOP_END),
        .SEGMENT    (SEGMENT),
        .START      (START),
        .STOP       (STOP),
        .PENDING    (PENDING),
        .ERR        (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check all five outputs at once.
    task automatic chk_out(input string tag, input logic seg, input logic st,
                           input logic sp, input logic pd, input logic er);
        chk({tag, ".SEGMENT"}, {63'd0, SEGMENT}, {63'd0, seg});
        chk({tag, ".START"},   {63'd0, START},   {63'd0, st});
        chk({tag, ".STOP"},    {63'd0, STOP},    {63'd0, sp});
        chk({tag, ".PENDING"}, {63'd0, PENDING}, {63'd0, pd});
        chk({tag, ".ERR"},     {63'd0, ERR},     {63'd0, er});
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_update(input logic seg, input logic [7:0] mode, input logic [63:0] value);
        UPDATE      = 1'b1;
        REQ_SEGMENT = seg;
        MODE        = mode;
        VALUE       = value;
        tick();
        UPDATE      = 1'b0;
    endtask

    task automatic pulse_loop();
        LOOP_END = 1'b1;
        tick();
        LOOP_END = 1'b0;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        RST_N       = 1'b0;
        UPDATE      = 1'b0;
        REQ_SEGMENT = 1'b0;
        MODE        = 8'h00;
        VALUE       = 64'd0;
        REP0        = 16'hFFFF;
        REP1        = 16'hFFFF;
        SYS_TIME    = 56'd0;
        GPIO_IN     = 4'b0000;
        LOOP_END    = 1'b0;

        // Reset state
        #1;
        chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        RST_N = 1'b1;
        tick();
        chk_out("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // SYNC_IDX: wait for LOOP_END, commit the cycle after
        do_update(1'b1, 8'h00, 64'd0);
        chk_out("sync_pend", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        chk_out("sync_hold", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        pulse_loop();
        chk_out("sync_commit", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("sync_after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Same segment: immediate restart without switching
        do_update(1'b1, 8'h00, 64'd0);
        chk_out("same_seg", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();

        // SYS_TIME ramp: compare true when 1000 presented, flip visible with 1001
        SYS_TIME = 56'd990;
        do_update(1'b0, 8'h01, 64'd1000);
        chk_out("time_pend", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 991; i <= 999; i++) begin
            SYS_TIME = 56'(i);
            tick();
            chk("time_ramp.SEGMENT", {63'd0, SEGMENT}, 64'd1);
            chk("time_ramp.PENDING", {63'd0, PENDING}, 64'd1);
        end
        SYS_TIME = 56'd1000;
        tick();
        chk_out("time_commit", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        SYS_TIME = 56'd1001;
        tick();
        chk_out("time_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // SYS_TIME already past: flip at t+2
        SYS_TIME = 56'd900;
        do_update(1'b1, 8'h01, 64'd5);
        chk_out("time_past_t1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk_out("time_past_t2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // GPIO: level held before UPDATE is not an edge; other pins ignored
        GPIO_IN = 4'b0100;
        tick();
        do_update(1'b0, 8'h02, 64'd2);
        chk_out("gpio_pend", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk_out("gpio_level", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        GPIO_IN = 4'b0101;
        tick();
        chk_out("gpio_pin0_hi", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        GPIO_IN = 4'b0100;
        tick();
        chk_out("gpio_pin0_lo", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        GPIO_IN = 4'b0000;
        tick();
        chk_out("gpio_fall", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        GPIO_IN = 4'b0100;
        tick();
        chk_out("gpio_commit", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        GPIO_IN = 4'b0000;
        tick();

        // EXT ping-pong: REP0=2 (3 loops), REP1=0 (1 loop)
        REP0 = 16'd2;
        REP1 = 16'd0;
        do_update(1'b0, 8'hF0, 64'd0);
        chk_out("ext_start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        pulse_loop();
        chk_out("ext_loop1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        pulse_loop();
        chk_out("ext_loop2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        pulse_loop();
        chk_out("ext_swap01", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("ext_swap01_after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse_loop();
        chk_out("ext_swap10", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();

        // Same repetitions without EXT: STOP after the 3rd loop end
        do_update(1'b0, 8'h00, 64'd0);
        chk_out("rep_restart", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        pulse_loop();
        chk_out("rep_loop1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        pulse_loop();
        chk_out("rep_loop2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        pulse_loop();
        chk_out("rep_stop", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        pulse_loop();
        chk_out("rep_ignored1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        pulse_loop();
        chk_out("rep_ignored2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Unsupported mode
        do_update(1'b1, 8'h07, 64'd0);
        chk_out("err_mode", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();

        // Valid UPDATE clears ERR; second UPDATE coinciding with LOOP_END wins
        do_update(1'b1, 8'h00, 64'd0);
        chk_out("ovl_first", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        SYS_TIME = 56'd900;
        LOOP_END = 1'b1;
        do_update(1'b1, 8'h01, 64'd2000);
        LOOP_END = 1'b0;
        chk_out("ovl_second", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        pulse_loop();
        chk_out("ovl_loop_noeffect", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        SYS_TIME = 56'd2000;
        tick();
        chk_out("ovl_commit", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();

        // Reset during WAIT_TIME with STOP set
        do_update(1'b0, 8'h01, 64'd5000);
        chk_out("rst_pend", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        pulse_loop();
        chk_out("rst_stop_set", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        #2;
        RST_N = 1'b0;
        #1;
        chk_out("rst_async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        SYS_TIME = 56'd6000;
        tick();
        RST_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("rst_release", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
